// File: rtl/ghost_mover.sv
// ghost_mover: per-frame chase controller for one sprite; steps its origin toward a target,
// holds a hit frame on contact, then parks the sprite off screen.
module ghost_mover #(
    parameter int H_RES = 640,
    parameter int V_RES = 480,
    parameter int SIZE = 32,
    parameter int STEP = 2,
    parameter int HIT_FRAMES = 30,
    parameter logic [10:0] OFF_POS = 11'h7FF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [10:0] x,
    input  logic [10:0] y,
    input  logic        spawn,
    input  logic [10:0] spawn_x,
    input  logic [10:0] spawn_y,
    input  logic [1:0]  spawn_color,
    input  logic [10:0] tgt_x,
    input  logic [10:0] tgt_y,
    input  logic [1:0]  speed,
    output logic [10:0] x0,
    output logic [10:0] y0,
    output logic [4:0]  ctrl,
    output logic        active,
    output logic        hit
);
    typedef enum logic [1:0] {IDLE, CHASE, HIT} state_t;

    localparam logic signed [11:0] X_MAX = 12'(H_RES - SIZE);
    localparam logic signed [11:0] Y_MAX = 12'(V_RES - SIZE);
    localparam logic signed [11:0] SZ = 12'(SIZE);
    localparam logic signed [11:0] STP = 12'(STEP);
    localparam logic [7:0] HC_LAST = 8'(HIT_FRAMES - 1);

    state_t r_state, w_state;
    logic [10:0] r_x_d1, r_x0, r_y0, w_x0, w_y0;
    logic [1:0] r_fc, w_fc, r_color, w_color;
    logic [7:0] r_hc, w_hc;
    logic r_hit, w_hit;
    logic w_frame_tick, w_move_tick, w_contact;
    logic signed [11:0] w_dx, w_dy;

    function automatic logic signed [11:0] f_abs(input logic signed [11:0] v);
        return v < 0 ? -v : v;
    endfunction

    // Move toward the target by at most STEP, never past it, then clamp to the screen.
    function automatic logic [10:0] f_step(input logic [10:0] p, input logic signed [11:0] d,
                                           input logic signed [11:0] hi);
        logic signed [11:0] a, s, n;
        a = f_abs(d);
        s = a < STP ? a : STP;
        n = d < 0 ? $signed({1'b0, p}) + s : $signed({1'b0, p}) - s;
        return n < 0 ? 11'd0 : n > hi ? hi[10:0] : n[10:0];
    endfunction

    function automatic logic [10:0] f_clamp(input logic [10:0] v, input logic signed [11:0] hi);
        return $signed({1'b0, v}) > hi ? hi[10:0] : v;
    endfunction

    assign w_frame_tick = (r_x_d1 == 11'd0) && (x == 11'd1) && (y == 11'd0);
    assign w_move_tick = w_frame_tick && (r_fc >= speed);
    assign w_dx = $signed({1'b0, r_x0}) - $signed({1'b0, tgt_x});
    assign w_dy = $signed({1'b0, r_y0}) - $signed({1'b0, tgt_y});
    assign w_contact = (f_abs(w_dx) < SZ) && (f_abs(w_dy) < SZ);

    always_comb begin
        w_state = r_state;
        w_x0 = r_x0;
        w_y0 = r_y0;
        w_color = r_color;
        w_hc = r_hc;
        w_hit = 1'b0;
        w_fc = w_frame_tick ? (w_move_tick ? 2'd0 : r_fc + 2'd1) : r_fc;
        case (r_state)
            IDLE, CHASE: begin
                if (spawn) begin
                    w_state = CHASE;
                    w_x0 = f_clamp(spawn_x, X_MAX);
                    w_y0 = f_clamp(spawn_y, Y_MAX);
                    w_color = spawn_color;
                    w_fc = 2'd0;
                end else if (r_state == CHASE && w_move_tick) begin
                    if (w_contact) begin
                        w_state = HIT;
                        w_hit = 1'b1;
                        w_hc = 8'd0;
                    end else begin
                        w_x0 = f_step(r_x0, w_dx, X_MAX);
                        w_y0 = f_step(r_y0, w_dy, Y_MAX);
                    end
                end
            end
            HIT: begin
                if (w_frame_tick) begin
                    if (r_hc == HC_LAST) begin
                        w_state = IDLE;
                        w_x0 = OFF_POS;
                        w_y0 = OFF_POS;
                        w_color = 2'd0;
                        w_hc = 8'd0;
                    end else begin
                        w_hc = r_hc + 8'd1;
                    end
                end
            end
            default: w_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_x_d1 <= 11'd0;
            r_x0 <= OFF_POS;
            r_y0 <= OFF_POS;
            r_color <= 2'd0;
            r_fc <= 2'd0;
            r_hc <= 8'd0;
            r_hit <= 1'b0;
        end else begin
            r_state <= w_state;
            r_x_d1 <= x;
            r_x0 <= w_x0;
            r_y0 <= w_y0;
            r_color <= w_color;
            r_fc <= w_fc;
            r_hc <= w_hc;
            r_hit <= w_hit;
        end
    end

    assign x0 = r_x0;
    assign y0 = r_y0;
    assign ctrl = r_state == CHASE ? {r_color, 3'b100} : r_state == HIT ? {r_color, 3'b011} : 5'd0;
    assign active = r_state != IDLE;
    assign hit = r_hit;
endmodule

// File: tb/tb_ghost_mover.sv
// tb_ghost_mover: directed vectors for ghost_mover with hand-computed expectations.
module tb_ghost_mover;
    logic clk = 1'b0, reset_n = 1'b0;
    logic [10:0] x = 11'd5, y = 11'd0, spawn_x = '0, spawn_y = '0, tgt_x = '0, tgt_y = '0;
    logic spawn = 1'b0;
    logic [1:0] spawn_color = '0, speed = '0;
    logic [10:0] x0, y0;
    logic [4:0] ctrl;
    logic active, hit;
    int n_vec = 0, n_err = 0;

    ghost_mover dut (
        .clk(clk), .reset_n(reset_n), .x(x), .y(y), .spawn(spawn), .spawn_x(spawn_x),
        .spawn_y(spawn_y), .spawn_color(spawn_color), .tgt_x(tgt_x), .tgt_y(tgt_y),
        .speed(speed), .x0(x0), .y0(y0), .ctrl(ctrl), .active(active), .hit(hit)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        x = 11'd0;
        cyc();
        x = 11'd1;
        cyc();
        x = 11'd5;
    endtask

    task automatic do_spawn(input logic [10:0] sx, input logic [10:0] sy, input logic [1:0] c);
        spawn = 1'b1;
        spawn_x = sx;
        spawn_y = sy;
        spawn_color = c;
        cyc();
        spawn = 1'b0;
    endtask

    initial begin
        cyc();
        cyc();
        chk("rst_x0", x0, 11'h7FF);
        chk("rst_y0", y0, 11'h7FF);
        chk("rst_ctrl", ctrl, 5'b00000);
        chk("rst_active", active, 1'b0);
        chk("rst_hit", hit, 1'b0);
        reset_n = 1'b1;
        cyc();
        speed = 2'd0;
        tgt_x = 11'd200;
        tgt_y = 11'd50;
        do_spawn(11'd100, 11'd50, 2'd2);
        chk("spawn_x0", x0, 11'd100);
        chk("spawn_y0", y0, 11'd50);
        chk("spawn_ctrl", ctrl, 5'b10100);
        chk("spawn_active", active, 1'b1);
        frame();
        chk("f1_x0", x0, 11'd102);
        chk("f1_y0", y0, 11'd50);
        for (int i = 0; i < 9; i++) frame();
        chk("f10_x0", x0, 11'd120);
        chk("f10_hit", hit, 1'b0);
        #1 reset_n = 1'b0;
        #1;
        chk("midrst_x0", x0, 11'h7FF);
        chk("midrst_y0", y0, 11'h7FF);
        chk("midrst_ctrl", ctrl, 5'b00000);
        chk("midrst_active", active, 1'b0);
        do_spawn(11'd10, 11'd10, 2'd1);
        chk("rst_spawn_x0", x0, 11'h7FF);
        chk("rst_spawn_active", active, 1'b0);
        reset_n = 1'b1;
        cyc();
        speed = 2'd3;
        do_spawn(11'd100, 11'd50, 2'd2);
        for (int i = 0; i < 3; i++) frame();
        chk("spd3_f3_x0", x0, 11'd100);
        frame();
        chk("spd3_f4_x0", x0, 11'd102);
        for (int i = 0; i < 3; i++) frame();
        chk("spd3_f7_x0", x0, 11'd102);
        frame();
        chk("spd3_f8_x0", x0, 11'd104);
        speed = 2'd0;
        do_spawn(11'd630, 11'd470, 2'd1);
        chk("clamp_x0", x0, 11'd608);
        chk("clamp_y0", y0, 11'd448);
        chk("clamp_ctrl", ctrl, 5'b01100);
        tgt_x = 11'd0;
        tgt_y = 11'd0;
        frame();
        chk("clamp_f1_x0", x0, 11'd606);
        chk("clamp_f1_y0", y0, 11'd446);
        x = 11'd0;
        cyc();
        x = 11'd1;
        do_spawn(11'd300, 11'd200, 2'd3);
        x = 11'd5;
        chk("tickspawn_x0", x0, 11'd300);
        chk("tickspawn_y0", y0, 11'd200);
        chk("tickspawn_ctrl", ctrl, 5'b11100);
        frame();
        chk("tickspawn_f1_x0", x0, 11'd298);
        chk("tickspawn_f1_y0", y0, 11'd198);
        tgt_x = 11'd170;
        tgt_y = 11'd50;
        do_spawn(11'd150, 11'd50, 2'd2);
        frame();
        chk("contact_hit", hit, 1'b1);
        chk("contact_x0", x0, 11'd150);
        chk("contact_ctrl", ctrl, 5'b10011);
        chk("contact_active", active, 1'b1);
        cyc();
        chk("contact_hit_off", hit, 1'b0);
        do_spawn(11'd400, 11'd400, 2'd1);
        chk("hitspawn_x0", x0, 11'd150);
        chk("hitspawn_ctrl", ctrl, 5'b10011);
        for (int i = 0; i < 29; i++) frame();
        chk("hit_f29_ctrl", ctrl, 5'b10011);
        chk("hit_f29_active", active, 1'b1);
        frame();
        chk("despawn_x0", x0, 11'h7FF);
        chk("despawn_y0", y0, 11'h7FF);
        chk("despawn_ctrl", ctrl, 5'b00000);
        chk("despawn_active", active, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
